program_out_uart_tx: RTL and testbench
======================================

// Module: program_out_uart_tx
// PURPOSE
//   Downstream consumer of the multi-cycle computer's program_out data word. Captures a
//   DATA_WIDTH-bit word on a valid strobe and serialises it as DATA_WIDTH/8 UART frames.
//   Frame format is 8N1: start 0, 8 data bits LSB first, stop 1. Least-significant byte goes first.
//   Double buffered: one holding register plus one active shifter, so the CPU can post the next
//   word while the current word is still on the line.
// PARAMETERS
//   DATA_WIDTH    24  word width taken from program_out; must be a multiple of 8
//   CLKS_PER_BIT  16  clock cycles per UART bit; must be >= 1
// PORTS
//   clock      in   1           system clock, rising edge
//   reset      in   1           asynchronous, active-high; clears all state
//   in_data    in   DATA_WIDTH  word to transmit (program_out)
//   in_valid   in   1           word present this cycle
//   in_ready   out  1           holding register empty; write is accepted when in_valid & in_ready
//   tx         out  1           serial line; idles high
//   busy       out  1           shifter active, or holding register full
//   overflow   out  1           sticky; set when in_valid & ~in_ready; cleared only by reset
// BEHAVIOUR
//   - Reset values: tx=1, in_ready=1, busy=0, overflow=0.
//     Holding register, shifter, and all counters cleared; FSM in IDLE.
//   - All outputs are registered. Reset takes effect immediately (asynchronous), including mid-frame.
//     A partial word is never resumed after reset.
//   - Accept: on edge E0 with in_valid & in_ready:
//     hold <= in_data; hold_full <= 1; in_ready = 0 after E0.
//   - Reject: in_valid while in_ready=0 drops the word and sets overflow at that edge.
//     Hold contents are unchanged.
//   - FSM states: IDLE, START, DATA, STOP.
//     IDLE: if hold_full, load shifter from hold, clear hold_full, byte_idx <= 0, go to START.
//       The start bit drives tx=0 from E1, i.e. one cycle after the accept edge.
//     START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit_idx <= 0.
//     DATA: tx = current_byte[bit_idx] for CLKS_PER_BIT cycles per bit.
//       After bit 7, go to STOP.
//     STOP: tx=1 for CLKS_PER_BIT cycles. When the stop bit ends:
//       if byte_idx < DATA_WIDTH/8-1: byte_idx++, go to START (no idle gap);
//       else if hold_full: reload shifter from hold, clear hold_full, go to START (back-to-back);
//       else go to IDLE.
//   - Baud counter counts 0..CLKS_PER_BIT-1 and reloads to 0 on every state/bit transition.
//     CLKS_PER_BIT=1 gives one cycle per bit.
//   - Word time = (DATA_WIDTH/8) * 10 * CLKS_PER_BIT cycles (480 at defaults).
//   - Simultaneous hold->shifter transfer and in_valid on the same edge:
//     in_ready was 0 that cycle, so the write is rejected and overflow sets.
//     in_ready rises on the following cycle.
//   - busy = (state != IDLE) | hold_full.
//     busy falls the cycle after the final stop bit completes with hold empty.
// TESTING
//   1. Assert reset for 3 cycles -> tx=1, in_ready=1, busy=0, overflow=0;
//      then 20 idle cycles -> tx stays 1.
//   2. Write 24'hA5C30F -> tx falls 1 cycle after accept; bytes 0x0F, 0xC3, 0xA5, LSB first,
//      16 cycles/bit sampled mid-bit; busy high for exactly 481 cycles.
//   3. Write 24'h123456, then 24'hABCDEF 50 cycles later -> in_ready=0 until the shifter loads;
//      second word's start bit directly follows first word's last stop bit, zero idle cycles.
//   4. With hold full, write 24'hFFFFFF -> overflow=1, word dropped;
//      serial stream carries only the first two words.
//   5. Assert reset during bit 3 of byte 1 -> tx=1 immediately (asynchronous);
//      after release, line stays idle; a new word then transmits cleanly from its start bit.
//   6. CLKS_PER_BIT=1, DATA_WIDTH=8, write 8'h81 -> tx = 0,1,0,0,0,0,0,0,1,1 on consecutive cycles.

Source files
------------

// File: rtl/program_out_uart_tx.sv
// Serialises each DATA_WIDTH word as 8N1 UART frames, LSB byte first; start bit one cycle after accept.
// Backpressure: in_ready low while the holding register is full; writes then are dropped and flag sticky overflow.
module program_out_uart_tx #(
  parameter int DATA_WIDTH   = 24,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  tx,
  output logic                  busy,
  output logic                  overflow
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(NUM_BYTES + 1);
  localparam logic [CW-1:0] BAUD_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(NUM_BYTES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state, state_n;
  logic [CW-1:0]         baud_cnt, baud_n;
  logic [2:0]            bit_idx, bit_n;
  logic [BW-1:0]         byte_idx, byte_n;
  logic [DATA_WIDTH-1:0] shifter, shift_n;
  logic [DATA_WIDTH-1:0] hold, hold_n;
  logic                  hold_full, hold_full_n;
  logic                  tx_n, busy_n, overflow_n;
  logic                  baud_done, load;

  assign baud_done = (baud_cnt == BAUD_MAX);
  assign in_ready  = ~hold_full;

  always_comb begin
    state_n     = state;
    baud_n      = baud_cnt;
    bit_n       = bit_idx;
    byte_n      = byte_idx;
    shift_n     = shifter;
    hold_n      = hold;
    hold_full_n = hold_full;
    load        = 1'b0;

    case (state)
      IDLE: begin
        if (hold_full) load = 1'b1;
      end
      START: begin
        if (baud_done) begin
          baud_n  = '0;
          bit_n   = 3'd0;
          state_n = DATA;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_n  = '0;
          shift_n = shifter >> 1;
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_n   = bit_idx + 3'd1;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_n = '0;
          if (byte_idx != LAST_BYTE) begin
            byte_n  = byte_idx + 1'b1;
            state_n = START;
          end else if (hold_full) begin
            load = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Shifter drains one bit per DATA bit, so the next byte is already at bit 0
    if (load) begin
      shift_n     = hold;
      hold_full_n = 1'b0;
      byte_n      = '0;
      bit_n       = 3'd0;
      baud_n      = '0;
      state_n     = START;
    end

    // Accept and load are exclusive: accept needs hold empty, load needs it full
    if (in_valid && !hold_full) begin
      hold_n      = in_data;
      hold_full_n = 1'b1;
    end

    overflow_n = overflow | (in_valid & hold_full);
    busy_n     = (state_n != IDLE) | hold_full_n;
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= 3'd0;
      byte_idx  <= '0;
      shifter   <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_idx   <= bit_n;
      byte_idx  <= byte_n;
      shifter   <= shift_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
      tx        <= tx_n;
      busy      <= busy_n;
      overflow  <= overflow_n;
    end
  end

endmodule

// File: tb/tb_program_out_uart_tx.sv
// Scoreboard bench: expected bytes queued at write time, popped as frames are decoded off tx.
module tb_program_out_uart_tx;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [23:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, tx, busy, overflow;
  logic [7:0]  in_data1 = '0;
  logic        in_valid1 = 1'b0;
  logic        in_ready1, tx1, busy1, overflow1;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];

  program_out_uart_tx #(.DATA_WIDTH(24), .CLKS_PER_BIT(16)) u_dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .busy(busy), .overflow(overflow)
  );

  program_out_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) u_fast (
    .clock(clock), .reset(reset), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .tx(tx1), .busy(busy1), .overflow(overflow1)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Called #1 after an edge; the next edge is the accept edge.
  task automatic write_word(input logic [23:0] d, output int acc_cyc);
    in_data  = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    acc_cyc  = cyc;
  endtask

  // Decodes one frame: start detected on first low cycle, bits sampled mid-bit.
  task automatic uart_rx(output logic [7:0] b, output logic stop_b, output int start_cyc, output bit ok);
    int n;
    n = 0; ok = 1'b0; b = '0; stop_b = 1'b0; start_cyc = 0;
    while (tx !== 1'b0 && n < 3000) begin step(); n++; end
    if (tx !== 1'b0) return;
    start_cyc = cyc;
    repeat (8) step();
    if (tx !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      repeat (16) step();
      b[i] = tx;
    end
    repeat (16) step();
    stop_b = tx;
    ok = 1'b1;
  endtask

  task automatic rx_and_check(input string name, input int nbytes, output int starts[6]);
    logic [7:0] b, e;
    logic sb;
    int sc;
    bit ok;
    for (int k = 0; k < 6; k++) starts[k] = 0;
    for (int k = 0; k < nbytes; k++) begin
      uart_rx(b, sb, sc, ok);
      starts[k] = sc;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      vectors++;
      if (!ok || b !== e || sb !== 1'b1) begin
        miscompares++;
        $display("FAIL %s byte%0d: got %h stop=%b decoded=%0d, expected %h stop=1", name, k, b, sb, ok, e);
      end
    end
  endtask

  task automatic test_reset();
    int lows;
    reset = 1'b1;
    repeat (3) step();
    vectors++;
    if ({tx, in_ready, busy, overflow} !== 4'b1100) begin
      miscompares++;
      $display("FAIL reset_state: tx/rdy/busy/ovf=%b, expected 1100", {tx, in_ready, busy, overflow});
    end
    vectors++;
    if ({tx1, in_ready1, busy1, overflow1} !== 4'b1100) begin
      miscompares++;
      $display("FAIL reset_state_fast: tx/rdy/busy/ovf=%b, expected 1100", {tx1, in_ready1, busy1, overflow1});
    end
    reset = 1'b0;
    lows = 0;
    repeat (20) begin step(); if (tx !== 1'b1) lows++; end
    vectors++;
    if (lows !== 0) begin
      miscompares++;
      $display("FAIL idle_line: %0d non-high cycles, expected 0", lows);
    end
  endtask

  task automatic test_single_word();
    int acc, nbusy;
    int starts[6];
    exp_q.push_back(8'h0F); exp_q.push_back(8'hC3); exp_q.push_back(8'hA5);
    write_word(24'hA5C30F, acc);
    vectors++;
    if ({tx, busy, in_ready} !== 3'b110) begin
      miscompares++;
      $display("FAIL after_accept: tx/busy/rdy=%b, expected 110", {tx, busy, in_ready});
    end
    nbusy = 0;
    fork
      begin
        while (busy === 1'b1 && nbusy < 2000) begin nbusy++; step(); end
      end
      rx_and_check("single", 3, starts);
    join
    vectors++;
    if (starts[0] !== acc + 1) begin
      miscompares++;
      $display("FAIL start_latency: start at cycle %0d, expected %0d", starts[0], acc + 1);
    end
    vectors++;
    if (nbusy !== 481) begin
      miscompares++;
      $display("FAIL busy_length: %0d cycles, expected 481", nbusy);
    end
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, acc3, rdy_cyc, n, lows;
    int starts[6];
    exp_q.push_back(8'h56); exp_q.push_back(8'h34); exp_q.push_back(8'h12);
    write_word(24'h123456, acc1);
    rdy_cyc = 0;
    fork
      rx_and_check("b2b", 6, starts);
      begin
        repeat (49) step();
        vectors++;
        if (in_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL rdy_after_load: in_ready=%b, expected 1", in_ready);
        end
        exp_q.push_back(8'hEF); exp_q.push_back(8'hCD); exp_q.push_back(8'hAB);
        write_word(24'hABCDEF, acc2);
        repeat (10) step();
        vectors++;
        if ({in_ready, overflow} !== 2'b00) begin
          miscompares++;
          $display("FAIL hold_full: rdy/ovf=%b, expected 00", {in_ready, overflow});
        end
        write_word(24'hFFFFFF, acc3);
        vectors++;
        if (overflow !== 1'b1) begin
          miscompares++;
          $display("FAIL overflow_set: overflow=%b, expected 1", overflow);
        end
        n = 0;
        while (in_ready !== 1'b1 && n < 1000) begin step(); n++; end
        rdy_cyc = cyc;
      end
    join
    vectors++;
    if (starts[1] - starts[0] !== 160 || starts[3] - starts[0] !== 480) begin
      miscompares++;
      $display("FAIL gapless: byte1 at +%0d, word2 at +%0d, expected +160 and +480",
               starts[1] - starts[0], starts[3] - starts[0]);
    end
    vectors++;
    if (rdy_cyc !== starts[3]) begin
      miscompares++;
      $display("FAIL rdy_rise: in_ready rose at %0d, expected %0d", rdy_cyc, starts[3]);
    end
    lows = 0;
    repeat (600) begin step(); if (tx !== 1'b1) lows++; end
    vectors++;
    if (lows !== 0 || busy !== 1'b0 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL dropped_word: low cycles=%0d busy=%b ovf=%b, expected 0 0 1", lows, busy, overflow);
    end
  endtask

  task automatic test_reset_midframe();
    int acc, lows;
    int starts[6];
    write_word(24'h66F712, acc);
    while (cyc < acc + 1 + 232) step();
    vectors++;
    if (tx !== 1'b0) begin
      miscompares++;
      $display("FAIL pre_reset_bit: tx=%b, expected 0 (byte1 bit3)", tx);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({tx, in_ready, busy, overflow} !== 4'b1100) begin
      miscompares++;
      $display("FAIL async_reset: tx/rdy/busy/ovf=%b, expected 1100", {tx, in_ready, busy, overflow});
    end
    repeat (2) step();
    reset = 1'b0;
    exp_q.delete();
    lows = 0;
    repeat (600) begin step(); if (tx !== 1'b1) lows++; end
    vectors++;
    if (lows !== 0) begin
      miscompares++;
      $display("FAIL post_reset_idle: %0d non-high cycles, expected 0", lows);
    end
    exp_q.push_back(8'h4E); exp_q.push_back(8'h9D); exp_q.push_back(8'h2B);
    write_word(24'h2B9D4E, acc);
    rx_and_check("after_reset", 3, starts);
    vectors++;
    if (starts[0] !== acc + 1) begin
      miscompares++;
      $display("FAIL restart_latency: start at %0d, expected %0d", starts[0], acc + 1);
    end
  endtask

  task automatic test_fast_baud();
    logic exp_bits[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    in_data1  = 8'h81;
    in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    vectors++;
    if (tx1 !== 1'b1) begin
      miscompares++;
      $display("FAIL fast_accept: tx=%b, expected 1", tx1);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++;
      if (tx1 !== exp_bits[i]) begin
        miscompares++;
        $display("FAIL fast_bit%0d: tx=%b, expected %b", i, tx1, exp_bits[i]);
      end
    end
    step();
    vectors++;
    if ({tx1, busy1} !== 2'b10) begin
      miscompares++;
      $display("FAIL fast_done: tx/busy=%b, expected 10", {tx1, busy1});
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_reset_midframe();
    test_fast_baud();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
